// File: rtl/byte_serial_adder.sv
// Byte-serial adder: W = 8*NBYTES bit operands are summed one 8-bit slice per
// clock, with valid/ready handshakes on both the operand and the result side.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IDXW-1:0] idx;
  logic            carry_q, cout_q, ovf_q;
  logic            accept, last_slice;
  logic [8:0]      slice;

  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == LAST_IDX);
  assign slice      = {1'b0, a_q[8*idx +: 8]} + {1'b0, b_q[8*idx +: 8]} + {8'd0, carry_q};

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults come first so every path assigns state_next and no latch
  // is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = ADD;
      ADD:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are only read after an
  // accept has loaded them, and accept is already gated by rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // The carry register doubles as the cin holder, so slice 0 needs no special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      carry_q <= cin;
    end else if (state == ADD) begin
      sum_q[8*idx +: 8] <= slice[7:0];
      carry_q           <= slice[8];
      idx               <= last_slice ? '0 : idx + 1'b1;
      if (last_slice) begin
        cout_q <= slice[8];
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice[7] != a_q[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder (NBYTES=4): fixed-latency handshakes,
// carry/overflow corners, backpressure, reset mid-operation, and a short random run.
module tb_byte_serial_adder;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE: accept, exact-latency check with junk on the
  // operand inputs and random out_ready during ADD, optional stall, then drain.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tc, input logic [31:0] es, input logic ec,
                       input logic eo, input int stall);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    step();
    a = $urandom; b = $urandom; cin = 1'b1;
    for (int k = 1; k <= NB; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      check({tag, "_valid_lat"}, out_valid, (k == NB));
      if (k == 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) step();
    check({tag, "_sum"},  sum,      es);
    check({tag, "_cout"}, cout,     ec);
    check({tag, "_ovf"},  ovf,      eo);
    check({tag, "_busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_idle"},    in_ready,  1'b1);
    check({tag, "_retain"},  sum,       es);
  endtask

  initial begin
    logic [31:0] ra, rb, hold_sum;
    logic        rc;
    logic [32:0] full;
    int          budget;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h1; b = 32'h1; cin = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready,  1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    do_op("basic",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);
    do_op("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
    do_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    do_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1);
    do_op("mixed",   32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 0);
    do_op("all_ones",32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);

    // Backpressure: 10 cycles in DONE with a competing request on the input.
    a = 32'd5; b = 32'd6; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 32'd100; b = 32'd200;
    repeat (NB) step();
    check("bp_valid", out_valid, 1'b1);
    for (int s = 0; s < 10; s++) begin
      step();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_sum",   sum,       32'd11);
      check("bp_hold_flags", {cout, ovf}, 2'b00);
      check("bp_in_ready",   in_ready,  1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_drain_idle",  in_ready,  1'b1);
    check("bp_drain_valid", out_valid, 1'b0);
    check("bp_drain_sum",   sum,       32'd11);

    // Reset on the second ADD edge abandons the operation.
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid",    out_valid, 1'b0);
    check("midrst_sum",      sum,       32'h0);
    check("midrst_in_ready", in_ready,  1'b1);
    repeat (NB) begin
      step();
      check("midrst_no_result", out_valid, 1'b0);
    end
    do_op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 0);

    // Reset wins over a concurrent drain in DONE.
    a = 32'h8000_0001; b = 32'h8000_0000; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (NB) step();
    check("rstdrain_sum_pre", sum, 32'h1);
    check("rstdrain_flags_pre", {cout, ovf}, 2'b11);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    #1;
    check("rstdrain_sum",   sum,         32'h0);
    check("rstdrain_flags", {cout, ovf}, 2'b00);
    check("rstdrain_valid", out_valid,   1'b0);
    check("rstdrain_ready", in_ready,    1'b1);

    // Short random run against a reference model, waiting on out_valid.
    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      repeat ($urandom_range(0, 2)) step();
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      step();
      in_valid = 1'b0; a = $urandom; b = $urandom;
      budget = 0;
      while (!out_valid && budget < 20) begin
        step();
        budget++;
      end
      check("rnd_latency", 32'(budget), 32'(NB));
      repeat ($urandom_range(0, 3)) step();
      hold_sum = full[31:0];
      check("rnd_sum",  sum,  hold_sum);
      check("rnd_cout", cout, full[32]);
      check("rnd_ovf",  ovf,  (ra[31] == rb[31]) && (full[31] != ra[31]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("rnd_drain", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
